// File: rtl/rv32_mem_pkg.sv
// Shared encodings, request payload and load extension helper for the RV32 data memory.
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [1:0]  byte_off;
    logic [31:0] wdata;
  } mem_req_t;

  // Select the addressed byte/half of a word and sign- or zero-extend it; words pass through.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  byte_off);
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    case (byte_off)
      2'd0:    sel_b = word[7:0];
      2'd1:    sel_b = word[15:8];
      2'd2:    sel_b = word[23:16];
      default: sel_b = word[31:24];
    endcase
    sel_h = byte_off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    return {{24{sel_b[7]}}, sel_b};
      F3_H:    return {{16{sel_h[15]}}, sel_h};
      F3_BU:   return {24'd0, sel_b};
      F3_HU:   return {16'd0, sel_h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for the data memory: misalignment decode, store lane enables and
// replication, and load lane select/extend.
module dmem_align
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  chk_size,
  input  logic [1:0]  chk_off,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  input  logic [31:0] read_word,
  output logic        misaligned_c,
  output logic [3:0]  byte_en_c,
  output logic [31:0] write_word_c,
  output logic [31:0] load_data_c
);

  // funct3[1:0]: 00 byte, 01 half, 1x word (reserved codes fall into word)
  always_comb begin
    misaligned_c = 1'b0;
    if (chk_size[1]) begin
      misaligned_c = |chk_off;
    end else if (chk_size[0]) begin
      misaligned_c = chk_off[0];
    end
  end

  always_comb begin
    byte_en_c    = 4'b1111;
    write_word_c = store_data;
    if (!funct3[1]) begin
      if (funct3[0]) begin
        byte_en_c    = byte_off[1] ? 4'b1100 : 4'b0011;
        write_word_c = {2{store_data[15:0]}};
      end else begin
        byte_en_c    = 4'b0001 << byte_off;
        write_word_c = {4{store_data[7:0]}};
      end
    end
  end

  assign load_data_c = load_extend(read_word, funct3, byte_off);

endmodule

// File: rtl/rv32_data_memory_ctrl.sv
// Byte-addressed RV32 data memory for the MEM stage with a fixed-latency BUSY_WAIT stall.
module rv32_data_memory_ctrl
  import rv32_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        BUSY_WAIT,
  output logic        MISALIGNED
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  mem_req_t         req;
  logic [IDX_W-1:0] req_idx;

  logic [3:0][7:0]  mem [DEPTH_WORDS];

  logic        is_idle;
  logic        misaligned_c;
  logic        request;
  logic        commit;
  logic        commit_wr;
  logic [3:0]  byte_en;
  logic [31:0] write_word;
  logic [31:0] load_data;
  logic [31:0] read_word;

  assign is_idle    = (state == ST_IDLE);
  assign MISALIGNED = (READ | WRITE) & is_idle & misaligned_c;
  assign request    = (READ | WRITE) & is_idle & ~misaligned_c;
  // The acceptance cycle raises the stall combinationally; ACCESS then holds it LATENCY cycles.
  assign BUSY_WAIT  = request | (state == ST_ACCESS);
  assign commit     = (state == ST_ACCESS) && (cnt == '0);
  assign commit_wr  = commit & req.write & ~RESET;
  assign read_word  = mem[req_idx];

  dmem_align u_align (
    .chk_size     (FUNCT3[1:0]),
    .chk_off      (ADDR[1:0]),
    .funct3       (req.funct3),
    .byte_off     (req.byte_off),
    .store_data   (req.wdata),
    .read_word    (read_word),
    .misaligned_c (misaligned_c),
    .byte_en_c    (byte_en),
    .write_word_c (write_word),
    .load_data_c  (load_data)
  );

  // Request FSM; DONE ignores READ/WRITE because the pipeline still presents the old request.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      DATA_OUT <= '0;
      req      <= '0;
      req_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (request) begin
            req.write    <= WRITE;
            req.funct3   <= FUNCT3;
            req.byte_off <= ADDR[1:0];
            req.wdata    <= DATA_IN;
            req_idx      <= ADDR[IDX_W+1:2];
            cnt          <= CNT_W'(LATENCY - 1);
            state        <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            if (!req.write) DATA_OUT <= load_data;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array has no reset so contents survive RESET.
  always_ff @(posedge CLK) begin
    if (commit_wr) begin
      for (int l = 0; l < 4; l++) begin
        if (byte_en[l]) mem[req_idx][l] <= write_word[8*l +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rv32_data_memory_ctrl.sv
// Directed bench for rv32_data_memory_ctrl at LATENCY 2, 1 and 5.
module tb_rv32_data_memory_ctrl;
  import rv32_mem_pkg::*;

  localparam int NDUT = 3;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        rd   [NDUT];
  logic        wr   [NDUT];
  logic [2:0]  f3   [NDUT];
  logic [31:0] addr [NDUT];
  logic [31:0] din  [NDUT];
  logic [31:0] dout [NDUT];
  logic        busy [NDUT];
  logic        mis  [NDUT];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          stall_cnt;
  logic [31:0] done_dout;

  always #5 CLK = ~CLK;

  rv32_data_memory_ctrl #(.DEPTH_WORDS(1024), .LATENCY(2)) dut0 (
    .CLK(CLK), .RESET(RESET), .READ(rd[0]), .WRITE(wr[0]), .FUNCT3(f3[0]), .ADDR(addr[0]),
    .DATA_IN(din[0]), .DATA_OUT(dout[0]), .BUSY_WAIT(busy[0]), .MISALIGNED(mis[0]));
  rv32_data_memory_ctrl #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .READ(rd[1]), .WRITE(wr[1]), .FUNCT3(f3[1]), .ADDR(addr[1]),
    .DATA_IN(din[1]), .DATA_OUT(dout[1]), .BUSY_WAIT(busy[1]), .MISALIGNED(mis[1]));
  rv32_data_memory_ctrl #(.DEPTH_WORDS(1024), .LATENCY(5)) dut2 (
    .CLK(CLK), .RESET(RESET), .READ(rd[2]), .WRITE(wr[2]), .FUNCT3(f3[2]), .ADDR(addr[2]),
    .DATA_IN(din[2]), .DATA_OUT(dout[2]), .BUSY_WAIT(busy[2]), .MISALIGNED(mis[2]));

  // One handshake: present at a negedge, count stalled cycles after acceptance, stop in DONE.
  task automatic access(input int d, input logic r, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] dat, input bit hold);
    bit done;
    @(negedge CLK);
    rd[d] = r; wr[d] = w; f3[d] = f; addr[d] = a; din[d] = dat;
    stall_cnt = 0;
    done = 1'b0;
    #1;
    n_checks++;
    if (busy[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL accept dut%0d addr=%h: BUSY_WAIT=%b required 1", d, a, busy[d]);
    end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK); #1;
      if (busy[d] === 1'b1) stall_cnt++;
      else done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout dut%0d addr=%h: BUSY_WAIT still 1 after 40 cycles", d, a);
    end
    done_dout = dout[d];
    if (!hold) begin
      rd[d] = 1'b0;
      wr[d] = 1'b0;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; f3[d] = F3_W; addr[d] = '0; din[d] = '0;
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      n_checks++;
      if (dout[d] !== 32'h0 || busy[d] !== 1'b0 || mis[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset dut%0d: DATA_OUT=%h BUSY=%b MIS=%b required 0/0/0",
                 d, dout[d], busy[d], mis[d]);
      end
    end
  endtask

  task automatic test_word();
    access(0, 1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b0);
    n_checks++;
    if (stall_cnt !== 2) begin
      n_fail++; $display("FAIL sw_stall: got %0d required 2", stall_cnt);
    end
    access(0, 1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b0);
    n_checks++;
    if (stall_cnt !== 2 || done_dout !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL lw_word: stall=%0d data=%h required 2/deadbeef", stall_cnt, done_dout);
    end
  endtask

  task automatic test_subword();
    logic [2:0]  lf  [6] = '{F3_W, F3_B, F3_BU, F3_HU, F3_H, F3_B};
    logic [31:0] la  [6] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12, 32'h11};
    logic [31:0] exp [6] = '{32'h80017FEF, 32'hFFFFFF80, 32'h00000080,
                             32'h00008001, 32'hFFFF8001, 32'h0000007F};
    access(0, 1'b0, 1'b1, F3_B, 32'h11, 32'hAAAAAA7F, 1'b0);
    n_checks++;
    if (done_dout !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL hold_on_store: DATA_OUT=%h required deadbeef", done_dout);
    end
    access(0, 1'b0, 1'b1, F3_H, 32'h12, 32'h55558001, 1'b0);
    for (int i = 0; i < 6; i++) begin
      access(0, 1'b1, 1'b0, lf[i], la[i], 32'h0, 1'b0);
      n_checks++;
      if (done_dout !== exp[i]) begin
        n_fail++;
        $display("FAIL load_%0d f3=%b addr=%h: got %h required %h", i, lf[i], la[i], done_dout, exp[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic        pr [3] = '{1'b1, 1'b0, 1'b1};
    logic [2:0]  pf [3] = '{F3_H, F3_W, F3_W};
    logic [31:0] pa [3] = '{32'h11, 32'h12, 32'h11};
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      rd[0] = pr[i]; wr[0] = ~pr[i]; f3[0] = pf[i]; addr[0] = pa[i]; din[0] = 32'hFFFFFFFF;
      #1;
      n_checks++;
      if (mis[0] !== 1'b1 || busy[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL misaligned_%0d: MIS=%b BUSY=%b required 1/0", i, mis[0], busy[0]);
      end
      repeat (2) @(negedge CLK);
      #1;
      n_checks++;
      if (busy[0] !== 1'b0 || dout[0] !== 32'h0000007F) begin
        n_fail++;
        $display("FAIL misaligned_hold_%0d: BUSY=%b DATA_OUT=%h required 0/0000007f", i, busy[0], dout[0]);
      end
      rd[0] = 1'b0; wr[0] = 1'b0;
    end
    access(0, 1'b0, 1'b1, F3_B, 32'h13, 32'h00000080, 1'b0);
    access(0, 1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b0);
    n_checks++;
    if (done_dout !== 32'h80017FEF) begin
      n_fail++; $display("FAIL misaligned_no_write: got %h required 80017fef", done_dout);
    end
  endtask

  task automatic test_reset_abort(input int d);
    access(d, 1'b0, 1'b1, F3_W, 32'h20, 32'hCAFEF00D, 1'b0);
    access(d, 1'b1, 1'b0, F3_W, 32'h20, 32'h0, 1'b0);
    @(negedge CLK);
    wr[d] = 1'b1; f3[d] = F3_W; addr[d] = 32'h20; din[d] = 32'h12345678;
    @(negedge CLK);
    RESET = 1'b1; wr[d] = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    n_checks++;
    if (busy[d] !== 1'b0 || dout[d] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_abort_state dut%0d: BUSY=%b DATA_OUT=%h required 0/0", d, busy[d], dout[d]);
    end
    access(d, 1'b1, 1'b0, F3_W, 32'h20, 32'h0, 1'b0);
    n_checks++;
    if (done_dout !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL reset_abort_mem dut%0d: got %h required cafef00d", d, done_dout);
    end
  endtask

  task automatic test_back_to_back();
    access(0, 1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1);
    n_checks++;
    if (done_dout !== 32'h80017FEF) begin
      n_fail++; $display("FAIL held_read_data: got %h required 80017fef", done_dout);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      rd[0] = 1'b0;
      #1;
      n_checks++;
      if (busy[0] !== 1'b0) begin
        n_fail++; $display("FAIL held_read_single_%0d: BUSY=%b required 0", i, busy[0]);
      end
    end
    access(0, 1'b1, 1'b1, F3_W, 32'h30, 32'h0BADF00D, 1'b0);
    n_checks++;
    if (stall_cnt !== 2 || done_dout !== 32'h80017FEF) begin
      n_fail++;
      $display("FAIL rw_store_wins: stall=%0d DATA_OUT=%h required 2/80017fef", stall_cnt, done_dout);
    end
    access(0, 1'b1, 1'b0, F3_W, 32'h30, 32'h0, 1'b0);
    n_checks++;
    if (done_dout !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL rw_readback: got %h required 0badf00d", done_dout);
    end
    access(0, 1'b0, 1'b1, F3_W, 32'h1000, 32'h11223344, 1'b0);
    access(0, 1'b1, 1'b0, F3_W, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (done_dout !== 32'h11223344) begin
      n_fail++; $display("FAIL alias_wrap: got %h required 11223344", done_dout);
    end
  endtask

  task automatic test_latency(input int d, input int lat, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] exp_h;
    exp_h = {{16{w[31]}}, w[31:16]};
    access(d, 1'b0, 1'b1, F3_W, a, w, 1'b0);
    n_checks++;
    if (stall_cnt !== lat) begin
      n_fail++; $display("FAIL lat%0d_store_stall: got %0d required %0d", lat, stall_cnt, lat);
    end
    access(d, 1'b1, 1'b0, F3_W, a, 32'h0, 1'b0);
    n_checks++;
    if (stall_cnt !== lat || done_dout !== w) begin
      n_fail++;
      $display("FAIL lat%0d_load: stall=%0d data=%h required %0d/%h", lat, stall_cnt, done_dout, lat, w);
    end
    access(d, 1'b1, 1'b0, F3_H, a + 32'h2, 32'h0, 1'b0);
    n_checks++;
    if (stall_cnt !== lat || done_dout !== exp_h) begin
      n_fail++;
      $display("FAIL lat%0d_lh: stall=%0d data=%h required %0d/%h", lat, stall_cnt, done_dout, lat, exp_h);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_misaligned();
    test_reset_abort(0);
    test_reset_abort(1);
    test_back_to_back();
    test_latency(1, 1, 32'h40, 32'hA5A55A5A);
    test_latency(2, 5, 32'h44, 32'h0F0F7E7E);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
